// File: rtl/cfa_window5x5_pkg.sv
// -----------------------------------------------------------------------------
// cfa_window5x5_pkg
// Shared definitions for the 5x5 CFA neighbourhood generator: default raw
// pixel width, window size, FSM state encoding and the line-slot helper used
// to address the rotating four-line buffer.
// -----------------------------------------------------------------------------
package cfa_window5x5_pkg;

    localparam int PIXEL_BW = 12;          // default raw pixel width
    localparam int WIN      = 5;           // window edge length
    localparam int LB_LINES = WIN - 1;     // lines held in the line buffer

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Line slots rotate modulo four; 2-bit wraparound gives that for free.
    function automatic logic [1:0] slot_add(input logic [1:0] base, input logic [1:0] offs);
        return base + offs;
    endfunction

endpackage

// File: rtl/cfa_line_buffer.sv
// -----------------------------------------------------------------------------
// cfa_line_buffer
// One entry per column; each entry packs the pixels of the four previous lines
// (slot s occupies bits [s*PW +: PW]). Read is combinational so the column can
// be assembled in the same cycle the new pixel arrives; the write replaces only
// the slot of the line currently being received (read-before-write on the
// same entry, since the write lands at the clock edge).
// Ports:
//   clk      in   clock
//   we       in   write enable (one accepted pixel)
//   addr     in   column address, shared by read and write
//   wr_slot  in   which of the four line slots receives wr_data
//   wr_data  in   pixel to store
//   rd_data  out  all four stored lines for column addr
// -----------------------------------------------------------------------------
module cfa_line_buffer #(
    parameter int PW    = 12,
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [1:0]          wr_slot,
    input  logic [PW-1:0]       wr_data,
    output logic [4*PW-1:0]     rd_data
);

    logic [4*PW-1:0] mem_r [DEPTH];

    // Store the accepted pixel into its line slot; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr][int'(wr_slot)*PW +: PW] <= wr_data;
        end
    end

    assign rd_data = mem_r[addr];

endmodule

// File: rtl/cfa_window5x5.sv
// -----------------------------------------------------------------------------
// cfa_window5x5
// Streaming 5x5 neighbourhood generator for the raw Bayer pipeline. Pixels
// arrive in raster order (gaps allowed), four previous lines live in
// cfa_line_buffer, and a 5x5 register array shifts one column per accepted
// pixel. A window is flagged valid only when fully populated (no padding).
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-low reset
//   start       in   frame start; clears position, arms a frame
//   pix_in      in   raw pixel
//   pix_valid   in   pix_in valid this cycle
//   eRtC        out  taps, row R (1 = oldest line), column C (1 = oldest)
//   win_valid   out  taps form a complete window this cycle
//   win_row     out  centre row of the presented window
//   win_col     out  centre column of the presented window
//   frame_done  out  one-cycle pulse after the frame's last pixel
// -----------------------------------------------------------------------------
module cfa_window5x5
    import cfa_window5x5_pkg::*;
#(
    parameter int pixelBitWidth = PIXEL_BW,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [pixelBitWidth-1:0]       pix_in,
    input  logic                           pix_valid,
    output logic [pixelBitWidth-1:0]       e1t1, e1t2, e1t3, e1t4, e1t5,
    output logic [pixelBitWidth-1:0]       e2t1, e2t2, e2t3, e2t4, e2t5,
    output logic [pixelBitWidth-1:0]       e3t1, e3t2, e3t3, e3t4, e3t5,
    output logic [pixelBitWidth-1:0]       e4t1, e4t2, e4t3, e4t4, e4t5,
    output logic [pixelBitWidth-1:0]       e5t1, e5t2, e5t3, e5t4, e5t5,
    output logic                           win_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0]  win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]   win_col,
    output logic                           frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int PW    = pixelBitWidth;

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_WIN_MIN  = COL_W'(WIN - 1);
    localparam logic [ROW_W-1:0] ROW_WIN_MIN  = ROW_W'(WIN - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_END = ROW_W'(WIN - 2);
    localparam logic [COL_W-1:0] COL_CTR_OFFS = COL_W'(WIN / 2);
    localparam logic [ROW_W-1:0] ROW_CTR_OFFS = ROW_W'(WIN / 2);

    state_e              state_r, state_nxt_s;
    logic [ROW_W-1:0]    row_r, cur_row_s;
    logic [COL_W-1:0]    col_r, cur_col_s;
    logic [1:0]          slot_r, cur_slot_s;      // line slot of the current row (row % 4)
    logic                accept_s;
    logic                frame_last_s;
    logic [4*PW-1:0]     lb_rd_s;
    logic [PW-1:0]       column_s [WIN];
    logic [PW-1:0]       tap_r    [WIN][WIN];
    logic                win_valid_r, frame_done_r;
    logic [ROW_W-1:0]    win_row_r;
    logic [COL_W-1:0]    win_col_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; start restarts from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = ST_FILL;
        end else begin
            case (state_r)
                ST_IDLE:   state_nxt_s = ST_IDLE;
                ST_FILL: begin
                    if (accept_s && (cur_row_s == ROW_FILL_END) && (cur_col_s == COL_LAST)) begin
                        state_nxt_s = ST_STREAM;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end
                ST_STREAM: begin
                    if (frame_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_STREAM;
                    end
                end
                ST_DONE:   state_nxt_s = ST_DONE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: pixels are taken only while a frame is armed (or on start).
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            ST_FILL, ST_STREAM: accept_s = pix_valid;
            ST_IDLE, ST_DONE:   accept_s = pix_valid & start;
            default:            accept_s = 1'b0;
        endcase
    end

    // Position of the pixel on the input this cycle; a start pixel is (0,0).
    always_comb begin
        if (start) begin
            cur_row_s  = {ROW_W{1'b0}};
            cur_col_s  = {COL_W{1'b0}};
            cur_slot_s = 2'd0;
        end else begin
            cur_row_s  = row_r;
            cur_col_s  = col_r;
            cur_slot_s = slot_r;
        end
        frame_last_s = accept_s && (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    end

    // Raster position counters, advanced per accepted pixel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_r  <= {ROW_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
            slot_r <= 2'd0;
        end else if (accept_s) begin
            if (cur_col_s == COL_LAST) begin
                col_r  <= {COL_W{1'b0}};
                row_r  <= (cur_row_s == ROW_LAST) ? {ROW_W{1'b0}} : cur_row_s + ROW_W'(1);
                slot_r <= slot_add(cur_slot_s, 2'd1);
            end else begin
                col_r  <= cur_col_s + COL_W'(1);
                row_r  <= cur_row_s;
                slot_r <= cur_slot_s;
            end
        end else if (start) begin
            row_r  <= {ROW_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
            slot_r <= 2'd0;
        end else begin
            row_r  <= row_r;
            col_r  <= col_r;
            slot_r <= slot_r;
        end
    end

    cfa_line_buffer #(
        .PW    (PW),
        .DEPTH (IMG_WIDTH),
        .AW    (COL_W)
    ) u_line_buffer (
        .clk     (clk),
        .we      (accept_s),
        .addr    (cur_col_s),
        .wr_slot (cur_slot_s),
        .wr_data (pix_in),
        .rd_data (lb_rd_s)
    );

    // Assemble the new column: the slot being overwritten holds the oldest
    // line (row-4), successive slots hold newer lines, pix_in is the newest.
    always_comb begin
        logic [1:0] sel;
        sel = 2'd0;
        for (int k = 0; k < LB_LINES; k++) begin
            sel         = slot_add(cur_slot_s, 2'(k));
            column_s[k] = lb_rd_s[int'(sel)*PW +: PW];
        end
        column_s[WIN-1] = pix_in;
    end

    // 5x5 tap array: shift left by one column per accepted pixel, new column at t5.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    tap_r[r][c] <= {PW{1'b0}};
                end
            end
        end else if (accept_s) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    tap_r[r][c] <= tap_r[r][c+1];
                end
                tap_r[r][WIN-1] <= column_s[r];
            end
        end else begin
            tap_r <= tap_r;
        end
    end

    // Window qualification and centre coordinates; stale columns are masked here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            win_row_r    <= {ROW_W{1'b0}};
            win_col_r    <= {COL_W{1'b0}};
        end else begin
            win_valid_r  <= accept_s && (cur_row_s >= ROW_WIN_MIN) && (cur_col_s >= COL_WIN_MIN);
            frame_done_r <= frame_last_s;
            if (accept_s && (cur_row_s >= ROW_WIN_MIN) && (cur_col_s >= COL_WIN_MIN)) begin
                win_row_r <= cur_row_s - ROW_CTR_OFFS;
                win_col_r <= cur_col_s - COL_CTR_OFFS;
            end else begin
                win_row_r <= win_row_r;
                win_col_r <= win_col_r;
            end
        end
    end

    assign win_valid  = win_valid_r;
    assign frame_done = frame_done_r;
    assign win_row    = win_row_r;
    assign win_col    = win_col_r;

    assign e1t1 = tap_r[0][0]; assign e1t2 = tap_r[0][1]; assign e1t3 = tap_r[0][2];
    assign e1t4 = tap_r[0][3]; assign e1t5 = tap_r[0][4];
    assign e2t1 = tap_r[1][0]; assign e2t2 = tap_r[1][1]; assign e2t3 = tap_r[1][2];
    assign e2t4 = tap_r[1][3]; assign e2t5 = tap_r[1][4];
    assign e3t1 = tap_r[2][0]; assign e3t2 = tap_r[2][1]; assign e3t3 = tap_r[2][2];
    assign e3t4 = tap_r[2][3]; assign e3t5 = tap_r[2][4];
    assign e4t1 = tap_r[3][0]; assign e4t2 = tap_r[3][1]; assign e4t3 = tap_r[3][2];
    assign e4t4 = tap_r[3][3]; assign e4t5 = tap_r[3][4];
    assign e5t1 = tap_r[4][0]; assign e5t2 = tap_r[4][1]; assign e5t3 = tap_r[4][2];
    assign e5t4 = tap_r[4][3]; assign e5t5 = tap_r[4][4];

endmodule
